// File: rtl/eighth_root_iter_pkg.sv
// Shared widths and FSM encoding for the eighth-root iterator.
package eighth_root_iter_pkg;

  localparam int IN_W_DEF  = 64;
  localparam int OUT_W_DEF = IN_W_DEF / 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SQ1  = 3'd1;
  localparam logic [2:0] ST_SQ2  = 3'd2;
  localparam logic [2:0] ST_SQ3  = 3'd3;
  localparam logic [2:0] ST_CMP  = 3'd4;

endpackage

// File: rtl/eighth_root_iter_if.sv
// Operand/result handshake bundle for the eighth-root iterator.
interface eighth_root_iter_if
  import eighth_root_iter_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = IN_W / 8
);

  logic             i_valid;
  logic [IN_W-1:0]  i_value;
  logic             o_ready;
  logic             o_valid;
  logic [OUT_W-1:0] o_value;

  modport slave (
    input  i_valid,
    input  i_value,
    output o_ready,
    output o_valid,
    output o_value
  );

  modport master (
    output i_valid,
    output i_value,
    input  o_ready,
    input  o_valid,
    input  o_value
  );

endinterface

// File: rtl/eighth_root_sq.sv
// Combinational truncating squarer; the single multiplier shared by all SQ states.
module eighth_root_sq
  import eighth_root_iter_pkg::*;
#(
  parameter int IN_W = IN_W_DEF
) (
  input  logic [IN_W-1:0] a_i,
  output logic [IN_W-1:0] sq_o
);

  assign sq_o = a_i * a_i;

endmodule

// File: rtl/eighth_root_iter.sv
// floor(X^(1/8)) by MSB-first bit search; each trial bit squares three times then compares.
module eighth_root_iter
  import eighth_root_iter_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = IN_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  eighth_root_iter_if.slave bus
);

  localparam int BIT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  logic [2:0]       state_q, state_d;
  logic [IN_W-1:0]  x_q, x_d;
  logic [IN_W-1:0]  p_q, p_d;
  logic [OUT_W-1:0] root_q, root_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [OUT_W-1:0] o_value_q, o_value_d;
  logic             o_valid_q, o_valid_d;

  logic [OUT_W-1:0] cand;
  logic [OUT_W-1:0] root_upd;
  logic [IN_W-1:0]  sq_in;
  logic [IN_W-1:0]  sq_out;

  assign cand     = root_q | (OUT_W'(1) << bit_q);
  assign root_upd = (p_q <= x_q) ? cand : root_q;

  // SQ1 squares the trial root; SQ2/SQ3 re-square the running product.
  assign sq_in = (state_q == ST_SQ1) ? {{(IN_W-OUT_W){1'b0}}, cand} : p_q;

  eighth_root_sq #(.IN_W(IN_W)) u_sq (
    .a_i  (sq_in),
    .sq_o (sq_out)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    p_d       = p_q;
    root_d    = root_q;
    bit_d     = bit_q;
    o_value_d = o_value_q;
    o_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          x_d     = bus.i_value;
          p_d     = '0;
          root_d  = '0;
          bit_d   = BIT_W'(OUT_W - 1);
          state_d = ST_SQ1;
        end
      end
      ST_SQ1: begin
        p_d     = sq_out;
        state_d = ST_SQ2;
      end
      ST_SQ2: begin
        p_d     = sq_out;
        state_d = ST_SQ3;
      end
      ST_SQ3: begin
        p_d     = sq_out;
        state_d = ST_CMP;
      end
      ST_CMP: begin
        root_d = root_upd;
        if (bit_q != '0) begin
          bit_d   = bit_q - BIT_W'(1);
          state_d = ST_SQ1;
        end else begin
          o_value_d = root_upd;
          o_valid_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      p_q       <= '0;
      root_q    <= '0;
      bit_q     <= '0;
      o_value_q <= '0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      p_q       <= p_d;
      root_q    <= root_d;
      bit_q     <= bit_d;
      o_value_q <= o_value_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign bus.o_ready = (state_q == ST_IDLE);
  assign bus.o_valid = o_valid_q;
  assign bus.o_value = o_value_q;

endmodule

// File: tb/tb_eighth_root_iter.sv
// Self-checking bench for eighth_root_iter against a brute-force integer eighth-root model.
module tb_eighth_root_iter;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  eighth_root_iter_if #(.IN_W(64)) bus ();

  eighth_root_iter #(.IN_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Largest k with k^8 <= x, found by exhaustive search in wide arithmetic.
  function automatic logic [7:0] root8(input logic [63:0] x);
    logic [127:0] p;
    for (int k = 255; k >= 0; k--) begin
      p = 128'd1;
      for (int j = 0; j < 8; j++) p = p * 128'(k);
      if (p <= {64'd0, x}) return 8'(k);
    end
    return 8'd0;
  endfunction

  function automatic logic [63:0] pow8(input int k);
    logic [63:0] p;
    p = 64'd1;
    for (int j = 0; j < 8; j++) p = p * 64'(k);
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [63:0] x, input string name);
    int   n;
    logic got;
    logic [7:0] exp_v;
    exp_v = root8(x);
    tests_run++;
    if (bus.o_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s ready_before_accept: got %b want 1", name, bus.o_ready);
    end
    bus.i_valid = 1'b1;
    bus.i_value = x;
    step();
    bus.i_valid = 1'b0;
    n   = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      step();
      n++;
      if (bus.o_valid === 1'b1) got = 1'b1;
    end
    tests_run++;
    if (!got || n != 32) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d (seen=%b) want 32", name, n, got);
    end
    tests_run++;
    if (bus.o_value !== exp_v) begin
      tests_failed++;
      $display("FAIL %s value: x=%0d got %0d want %0d", name, x, bus.o_value, exp_v);
    end
    step();
    tests_run++;
    if (bus.o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s pulse_width: o_valid still %b want 0", name, bus.o_valid);
    end
  endtask

  task automatic test_reset();
    int pulses;
    reset       = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_value = '0;
    step();
    step();
    reset = 1'b0;
    tests_run++;
    if (bus.o_valid !== 1'b0 || bus.o_value !== 8'd0 || bus.o_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%b value=%0d ready=%b want 0 0 1",
               bus.o_valid, bus.o_value, bus.o_ready);
    end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.o_valid === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++;
      $display("FAIL reset_idle_pulses: got %0d want 0", pulses);
    end
  endtask

  task automatic test_exact_powers();
    run_one(64'd0, "exact_0");
    run_one(64'd1, "exact_1");
    run_one(64'd6561, "exact_3pow8");
    run_one(64'd256, "exact_2pow8");
    run_one(64'd17878103347812890625, "exact_255pow8");
  endtask

  task automatic test_off_by_one();
    run_one(64'd6560, "obo_6560");
    run_one(64'd255, "obo_255");
    run_one(64'd17878103347812890624, "obo_255pow8_m1");
    run_one(64'hFFFF_FFFF_FFFF_FFFF, "obo_max");
  endtask

  task automatic test_random();
    int k;
    logic [63:0] x;
    for (int i = 0; i < 8; i++) begin
      x = {$urandom, $urandom};
      run_one(x, "rand_full");
    end
    for (int i = 0; i < 4; i++) begin
      x = 64'($urandom_range(0, 100000));
      run_one(x, "rand_small");
    end
    for (int i = 0; i < 4; i++) begin
      k = int'($urandom_range(1, 255));
      run_one(pow8(k), "rand_pow");
      run_one(pow8(k) - 64'd1, "rand_pow_m1");
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] q[$];
    logic [63:0] e;
    int idx, results, cyc, last;
    idx = 0; results = 0; cyc = 0; last = -1;
    while (results < 10 && cyc < 500) begin
      if (bus.o_ready === 1'b1) begin
        if (idx < 10) begin
          bus.i_valid = 1'b1;
          bus.i_value = 64'(idx);
          q.push_back(64'(idx));
          idx++;
        end else begin
          bus.i_valid = 1'b0;
        end
      end
      step();
      cyc++;
      if (bus.o_valid === 1'b1) begin
        results++;
        e = (q.size() > 0) ? q.pop_front() : 64'd0;
        tests_run++;
        if (bus.o_value !== root8(e)) begin
          tests_failed++;
          $display("FAIL b2b_value: x=%0d got %0d want %0d", e, bus.o_value, root8(e));
        end
        tests_run++;
        if (bus.o_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_ready_on_strobe: got %b want 1", bus.o_ready);
        end
        if (last >= 0) begin
          tests_run++;
          if (cyc - last != 33) begin
            tests_failed++;
            $display("FAIL b2b_spacing: got %0d want 33", cyc - last);
          end
        end
        last = cyc;
      end
    end
    bus.i_valid = 1'b0;
    tests_run++;
    if (results != 10) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d want 10", results);
    end
    step();
  endtask

  task automatic test_busy_ignore();
    int pulses, ready_bad, got_n;
    logic [7:0] val;
    pulses = 0; ready_bad = 0; got_n = -1; val = '0;
    bus.i_valid = 1'b1;
    bus.i_value = 64'd6561;
    step();
    for (int n = 1; n <= 80; n++) begin
      if (n >= 5 && n <= 20) begin
        bus.i_valid = 1'b1;
        bus.i_value = 64'd256;
      end else begin
        bus.i_valid = 1'b0;
      end
      step();
      if (n < 32 && bus.o_ready !== 1'b0) ready_bad++;
      if (bus.o_valid === 1'b1) begin
        pulses++;
        if (got_n < 0) begin
          got_n = n;
          val   = bus.o_value;
        end
      end
    end
    tests_run++;
    if (ready_bad != 0) begin
      tests_failed++;
      $display("FAIL busy_ready_low: %0d busy cycles with ready!=0, want 0", ready_bad);
    end
    tests_run++;
    if (pulses != 1) begin
      tests_failed++;
      $display("FAIL busy_pulse_count: got %0d want 1", pulses);
    end
    tests_run++;
    if (got_n != 32 || val !== 8'd3) begin
      tests_failed++;
      $display("FAIL busy_result: at %0d value %0d, want at 32 value 3", got_n, val);
    end
  endtask

  task automatic test_midop_reset();
    int pulses;
    bus.i_valid = 1'b1;
    bus.i_value = 64'd6561;
    step();
    bus.i_valid = 1'b0;
    for (int n = 1; n < 10; n++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests_run++;
    if (bus.o_valid !== 1'b0 || bus.o_value !== 8'd0 || bus.o_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midop_reset_state: valid=%b value=%0d ready=%b want 0 0 1",
               bus.o_valid, bus.o_value, bus.o_ready);
    end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.o_valid === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++;
      $display("FAIL midop_no_pulse: got %0d want 0", pulses);
    end
    run_one(64'd256, "midop_after");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    bus.i_valid  = 1'b0;
    bus.i_value  = '0;
    test_reset();
    test_exact_powers();
    test_off_by_one();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_midop_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
